ldpc_dvb_dec_cnode_msg_gen: RTL and testbench

Serial check-node message generator for the min-sum LDPC DVB-S2 decoder, placed directly downstream of the serial sort engine. It captures the per-column sign and mask of the variable-node stream fed to the sort engine, then takes the row's sort result and emits one check-to-variable message per column. Each message carries the min1/min2 magnitude, excluding the column itself, with the extrinsic sign. The block double-buffers signs so that one row can be captured while the previous row is being emitted.

---
 rtl/ldpc_dvb_dec_cnode_msg_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_ldpc_dvb_dec_cnode_msg_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_dvb_dec_cnode_msg_gen.sv
//------------------------------------------------------------------------------
// ldpc_dvb_dec_cnode_msg_gen
//
// Serial check-node message generator for the min-sum DVB-S2 LDPC decoder.
// It sits right after the serial sort engine. The variable-node stream that
// feeds the sort engine is also captured here: for each column we keep
// {sign, mask}, and the storage is split into two banks so that one row can
// be captured while the previous one is being emitted. When a row's sort
// result (min1/min2/min1_col/prod_sign) arrives, one check-to-variable
// message per column is emitted: the magnitude that excludes the column
// itself, saturated, with the extrinsic sign.
//
// Ports:
//   iclk, ireset_n     clock, asynchronous active-low reset
//   iclkena            clock enable; all state holds when low
//   istart             synchronous clear of pointers, FSM and overflow flag
//   ival/isop/ieop     variable-node stream valid, first/last column
//   ivmask, ivnode     column mask, variable-node value (only MSB is kept)
//   isort_*            sort result for one row (one-cycle valid pulse)
//   oval/osop/oeop     message valid, first/last message of the row
//   ocol, omsg, omask  column index, signed message, column-masked flag
//   obusy              emission active or result pending
//   oovf               sticky: a sort result arrived with the queue full
//------------------------------------------------------------------------------
module ldpc_dvb_dec_cnode_msg_gen #(
   parameter int pNODE_W = 8,
   parameter int pCOL_W  = 5
) (
   input  logic                iclk,
   input  logic                ireset_n,
   input  logic                iclkena,
   input  logic                istart,
   input  logic                ival,
   input  logic                isop,
   input  logic                ieop,
   input  logic                ivmask,
   input  logic [pNODE_W-1:0]  ivnode,
   input  logic                isort_val,
   input  logic                isort_prod_sign,
   input  logic [pNODE_W-1:0]  isort_min1,
   input  logic [pNODE_W-1:0]  isort_min2,
   input  logic [pCOL_W-1:0]   isort_min1_col,
   input  logic [pCOL_W-1:0]   isort_num_m1,
   output logic                oval,
   output logic                osop,
   output logic                oeop,
   output logic [pCOL_W-1:0]   ocol,
   output logic [pNODE_W-1:0]  omsg,
   output logic                omask,
   output logic                obusy,
   output logic                oovf
);

   localparam int DEPTH = 2 ** pCOL_W;
   localparam logic [pCOL_W-1:0]  COL_ZERO  = {pCOL_W{1'b0}};
   localparam logic [pCOL_W-1:0]  COL_ONE   = {{(pCOL_W-1){1'b0}}, 1'b1};
   localparam logic [pNODE_W-1:0] NODE_ZERO = {pNODE_W{1'b0}};
   localparam logic [pNODE_W-1:0] MAG_MAX   = {1'b0, {(pNODE_W-1){1'b1}}};

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   typedef struct packed {
      logic               prod_sign;
      logic [pNODE_W-1:0] min1;
      logic [pNODE_W-1:0] min2;
      logic [pCOL_W-1:0]  min1_col;
      logic [pCOL_W-1:0]  num_m1;
   } res_t;

   localparam int   RES_W    = $bits(res_t);
   localparam res_t RES_ZERO = res_t'({RES_W{1'b0}});

   // Message for one column: the other-minimum magnitude, clipped so that the
   // negation stays representable, signed by the extrinsic sign.
   function automatic logic [pNODE_W-1:0] msg_calc(input res_t r, input logic [pCOL_W-1:0] col,
                                                   input logic sbit, input logic mbit);
      logic [pNODE_W-1:0] mag;
      logic [pNODE_W-1:0] sat;
      mag = (col == r.min1_col) ? r.min2 : r.min1;
      sat = mag[pNODE_W-1] ? MAG_MAX : mag;
      if (mbit)
         msg_calc = NODE_ZERO;
      else if (r.prod_sign ^ sbit)
         msg_calc = NODE_ZERO - sat;
      else
         msg_calc = sat;
   endfunction

   // {sign, mask} per column; banks addressed by the top index bit
   logic [1:0]          sbuf_r [2*DEPTH];
   logic                wbank_r, rbank_r;
   logic [pCOL_W-1:0]   wcol_r, rcol_r;
   logic [pCOL_W-1:0]   wcol_s;
   state_t              state_r, nstate_s;
   res_t                act_r, pend_r, nact_s, npend_s, in_res_s;
   logic                pend_vld_r, npvld_s, novf_s;
   logic [pCOL_W-1:0]   ncol_s;
   logic                nrbank_s;
   logic [1:0]          rd_s;
   logic                nval_s;
   logic                unused_s;

   // The magnitude bits of the variable-node value are not needed here
   assign unused_s = ^ivnode[pNODE_W-2:0];

   assign wcol_s   = isop ? COL_ZERO : wcol_r;
   assign in_res_s = '{prod_sign: isort_prod_sign, min1: isort_min1, min2: isort_min2,
                       min1_col: isort_min1_col, num_m1: isort_num_m1};

   // Sign buffer write; contents need no reset
   always_ff @(posedge iclk) begin
      if (iclkena && ival && !istart)
         sbuf_r[{wbank_r, wcol_s}] <= {ivmask ? 1'b0 : ivnode[pNODE_W-1], ivmask};
   end

   // Next-state, result queue and read pointer logic
   always_comb begin
      nstate_s = state_r;
      ncol_s   = rcol_r;
      nrbank_s = rbank_r;
      nact_s   = act_r;
      npend_s  = pend_r;
      npvld_s  = pend_vld_r;
      novf_s   = oovf;
      case (state_r)
         IDLE: begin
            if (pend_vld_r) begin
               nact_s   = pend_r;
               npend_s  = in_res_s;
               npvld_s  = isort_val;
               nstate_s = EMIT;
               ncol_s   = COL_ZERO;
            end else if (isort_val) begin
               nact_s   = in_res_s;
               nstate_s = EMIT;
               ncol_s   = COL_ZERO;
            end else begin
               nstate_s = IDLE;
            end
         end
         EMIT: begin
            if (rcol_r < act_r.num_m1) begin
               ncol_s = rcol_r + COL_ONE;
               if (isort_val && !pend_vld_r) begin
                  npend_s = in_res_s;
                  npvld_s = 1'b1;
               end else if (isort_val) begin
                  novf_s = 1'b1;
               end else begin
                  npvld_s = pend_vld_r;
               end
            end else begin
               // Last column: the pending slot frees up this cycle, so a
               // result arriving now can take its place.
               nrbank_s = ~rbank_r;
               ncol_s   = COL_ZERO;
               if (pend_vld_r) begin
                  nact_s  = pend_r;
                  npend_s = in_res_s;
                  npvld_s = isort_val;
               end else if (isort_val) begin
                  nact_s = in_res_s;
               end else begin
                  nstate_s = IDLE;
               end
            end
         end
         default: begin
            nstate_s = IDLE;
            npvld_s  = 1'b0;
         end
      endcase
   end

   // Outputs are precomputed from the next state so they can be registered
   assign rd_s   = sbuf_r[{nrbank_s, ncol_s}];
   assign nval_s = (nstate_s == EMIT);

   // State, pointers and registered outputs
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state_r    <= IDLE;
         wbank_r    <= 1'b0;
         rbank_r    <= 1'b0;
         wcol_r     <= COL_ZERO;
         rcol_r     <= COL_ZERO;
         act_r      <= RES_ZERO;
         pend_r     <= RES_ZERO;
         pend_vld_r <= 1'b0;
         oval       <= 1'b0;
         osop       <= 1'b0;
         oeop       <= 1'b0;
         ocol       <= COL_ZERO;
         omsg       <= NODE_ZERO;
         omask      <= 1'b0;
         obusy      <= 1'b0;
         oovf       <= 1'b0;
      end else if (iclkena) begin
         if (istart) begin
            state_r    <= IDLE;
            wbank_r    <= 1'b0;
            rbank_r    <= 1'b0;
            wcol_r     <= COL_ZERO;
            rcol_r     <= COL_ZERO;
            pend_vld_r <= 1'b0;
            oval       <= 1'b0;
            osop       <= 1'b0;
            oeop       <= 1'b0;
            ocol       <= COL_ZERO;
            omsg       <= NODE_ZERO;
            omask      <= 1'b0;
            obusy      <= 1'b0;
            oovf       <= 1'b0;
         end else begin
            if (ival) begin
               wcol_r <= wcol_s + COL_ONE;
               if (ieop)
                  wbank_r <= ~wbank_r;
            end
            state_r    <= nstate_s;
            rcol_r     <= ncol_s;
            rbank_r    <= nrbank_s;
            act_r      <= nact_s;
            pend_r     <= npend_s;
            pend_vld_r <= npvld_s;
            oval       <= nval_s;
            osop       <= nval_s && (ncol_s == COL_ZERO);
            oeop       <= nval_s && (ncol_s == nact_s.num_m1);
            ocol       <= nval_s ? ncol_s : COL_ZERO;
            omsg       <= nval_s ? msg_calc(nact_s, ncol_s, rd_s[1], rd_s[0]) : NODE_ZERO;
            omask      <= nval_s && rd_s[0];
            obusy      <= nval_s;
            oovf       <= novf_s;
         end
      end
   end

endmodule

// File: tb/tb_ldpc_dvb_dec_cnode_msg_gen.sv
module tb_ldpc_dvb_dec_cnode_msg_gen;

   logic       iclk = 1'b0;
   logic       ireset_n, iclkena, istart, ival, isop, ieop, ivmask;
   logic [7:0] ivnode;
   logic       isort_val, isort_prod_sign;
   logic [7:0] isort_min1, isort_min2;
   logic [4:0] isort_min1_col, isort_num_m1;
   logic       oval, osop, oeop, omask, obusy, oovf;
   logic [4:0] ocol;
   logic [7:0] omsg;

   ldpc_dvb_dec_cnode_msg_gen #(.pNODE_W(8), .pCOL_W(5)) dut (
      .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .istart(istart),
      .ival(ival), .isop(isop), .ieop(ieop), .ivmask(ivmask), .ivnode(ivnode),
      .isort_val(isort_val), .isort_prod_sign(isort_prod_sign),
      .isort_min1(isort_min1), .isort_min2(isort_min2),
      .isort_min1_col(isort_min1_col), .isort_num_m1(isort_num_m1),
      .oval(oval), .osop(osop), .oeop(oeop), .ocol(ocol), .omsg(omsg),
      .omask(omask), .obusy(obusy), .oovf(oovf)
   );

   always #5 iclk = ~iclk;

   int cyc = 0;
   always @(posedge iclk) cyc <= cyc + 1;

   typedef struct {
      int         t;
      logic [4:0] col;
      logic [7:0] msg;
      logic       sop, eop, mask;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] row_s_q[$];
   logic [31:0] row_m_q[$];
   int          last_s = -100;
   int          last_e = -100;
   int          ovf_from = 1 << 30;
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  cap_v[32];
   logic        cap_m[32];

   task automatic tick;
      @(posedge iclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_oval"}, oval, 0);
      chk({tag, "_osop"}, osop, 0);
      chk({tag, "_oeop"}, oeop, 0);
      chk({tag, "_omask"}, omask, 0);
      chk({tag, "_obusy"}, obusy, 0);
      chk({tag, "_oovf"}, oovf, 0);
      chk({tag, "_ocol"}, ocol, 0);
      chk({tag, "_omsg"}, omsg, 0);
   endtask

   task automatic model_clear;
      exp_q.delete();
      row_s_q.delete();
      row_m_q.delete();
      last_s   = -100;
      last_e   = -100;
      ovf_from = 1 << 30;
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) begin
         cap_v[i] = 8'($urandom);
         cap_m[i] = ($urandom_range(0, 7) == 0);
      end
   endtask

   // Drive one row on the variable-node stream and remember its signs/masks
   task automatic capture(input int n);
      logic [31:0] s, m;
      s = 32'd0;
      m = 32'd0;
      for (int i = 0; i < n; i++) begin
         ival   = 1'b1;
         isop   = (i == 0);
         ieop   = (i == n - 1);
         ivnode = cap_v[i];
         ivmask = cap_m[i];
         s[i]   = cap_m[i] ? 1'b0 : cap_v[i][7];
         m[i]   = cap_m[i];
         tick;
      end
      ival = 1'b0; isop = 1'b0; ieop = 1'b0; ivmask = 1'b0; ivnode = 8'd0;
      row_s_q.push_back(s);
      row_m_q.push_back(m);
   endtask

   // Issue a sort result; predict acceptance and the timed message sequence
   task automatic issue(input logic p, input logic [7:0] m1, input logic [7:0] m2,
                        input logic [4:0] mc, input logic [4:0] nm);
      int t, s, mag, v;
      logic [31:0] sg, mk;
      exp_t e;
      t = cyc;
      if (last_s > t + 1) begin
         // one row emitting and another already waiting: this one is lost
         if (ovf_from > t + 1) ovf_from = t + 1;
      end else begin
         s  = (t + 1 > last_e + 1) ? t + 1 : last_e + 1;
         sg = row_s_q.pop_front();
         mk = row_m_q.pop_front();
         for (int c = 0; c <= int'(nm); c++) begin
            mag = (c == int'(mc)) ? int'(m2) : int'(m1);
            if (mag > 127) mag = 127;
            v = (p ^ sg[c]) ? -mag : mag;
            e.t    = s + c;
            e.col  = c[4:0];
            e.msg  = mk[c] ? 8'd0 : v[7:0];
            e.sop  = (c == 0);
            e.eop  = (c == int'(nm));
            e.mask = mk[c];
            exp_q.push_back(e);
         end
         last_s = s;
         last_e = s + int'(nm);
      end
      isort_val = 1'b1; isort_prod_sign = p; isort_min1 = m1; isort_min2 = m2;
      isort_min1_col = mc; isort_num_m1 = nm;
      tick;
      isort_val = 1'b0;
   endtask

   task automatic issue_rand(input int n);
      logic [7:0] m1, m2;
      m1 = 8'($urandom_range(0, 255));
      m2 = 8'($urandom_range(int'(m1), 255));
      issue(1'($urandom), m1, m2, 5'($urandom_range(0, 31)), 5'(n - 1));
   endtask

   task automatic do_istart;
      istart = 1'b1;
      tick;
      istart = 1'b0;
      model_clear();
      chk("istart_oval", oval, 0);
      chk("istart_oovf", oovf, 0);
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         tick;
      end
      chk("idle_timeout", exp_q.size(), 0);
      exp_q.delete();
      tick;
   endtask

   // Monitor: every cycle, the DUT must show exactly the scheduled message
   always @(negedge iclk) begin
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
         e = exp_q.pop_front();
         chk("oval", oval, 1);
         chk("obusy_emit", obusy, 1);
         chk("ocol", ocol, e.col);
         chk("omsg", omsg, e.msg);
         chk("osop", osop, e.sop);
         chk("oeop", oeop, e.eop);
         chk("omask", omask, e.mask);
      end else begin
         chk("oval_idle", oval, 0);
         chk("obusy_idle", obusy, 0);
      end
      chk("oovf", oovf, (cyc >= ovf_from));
   end

   initial begin
      ireset_n = 1'b0; iclkena = 1'b1; istart = 1'b0;
      ival = 1'b0; isop = 1'b0; ieop = 1'b0; ivmask = 1'b0; ivnode = 8'd0;
      isort_val = 1'b0; isort_prod_sign = 1'b0; isort_min1 = 8'd0; isort_min2 = 8'd0;
      isort_min1_col = 5'd0; isort_num_m1 = 5'd0;
      #23;
      chk_zero("reset");
      ireset_n = 1'b1;
      tick;

      // basic row: +5, -3, +7, -2
      cap_v[0] = 8'd5; cap_v[1] = 8'hFD; cap_v[2] = 8'd7; cap_v[3] = 8'hFE;
      for (int i = 0; i < 4; i++) cap_m[i] = 1'b0;
      capture(4);
      issue(1'b0, 8'd2, 8'd3, 5'd3, 5'd3);
      wait_idle();

      // saturation and sign
      for (int i = 0; i < 4; i++) begin cap_v[i] = 8'h01; cap_m[i] = 1'b0; end
      capture(4);
      issue(1'b1, 8'h80, 8'hFF, 5'd0, 5'd3);
      wait_idle();

      // masked middle column
      cap_v[0] = 8'h10; cap_v[1] = 8'h90; cap_v[2] = 8'hF0;
      cap_m[0] = 1'b0;  cap_m[1] = 1'b1;  cap_m[2] = 1'b0;
      capture(3);
      issue(1'b0, 8'd4, 8'd9, 5'd1, 5'd2);
      wait_idle();

      // back-to-back 8-column rows
      fill_rand(8); capture(8);
      fill_rand(8); capture(8);
      issue_rand(8);
      tick; tick; tick;
      issue_rand(8);
      wait_idle();

      // single-column row
      fill_rand(1); capture(1);
      issue(1'b1, 8'd7, 8'd20, 5'd0, 5'd0);
      wait_idle();

      // overflow: third result during a 16-column emission is dropped
      fill_rand(16); capture(16);
      fill_rand(16); capture(16);
      issue_rand(16);
      issue_rand(16);
      issue_rand(16);
      repeat (20) tick;
      chk("ovf_sticky", oovf, 1);
      do_istart();
      tick;

      // asynchronous reset in the middle of a row
      fill_rand(12); capture(12);
      issue_rand(12);
      repeat (4) tick;
      #2 ireset_n = 1'b0;
      #1 chk_zero("midrow_reset");
      model_clear();
      #2 ireset_n = 1'b1;
      tick;

      // randomized single rows and overlapping pairs
      for (int k = 0; k < 30; k++) begin
         int na, nb;
         na = $urandom_range(1, 32);
         nb = $urandom_range(1, 32);
         fill_rand(na); capture(na);
         if ($urandom_range(0, 1) == 1) begin
            fill_rand(nb); capture(nb);
            issue_rand(na);
            repeat ($urandom_range(0, na + 2)) tick;
            issue_rand(nb);
         end else begin
            issue_rand(na);
         end
         wait_idle();
      end

      repeat (3) tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
